// File: rtl/pcileech_tlp_rx_dw_serializer.sv
// Store-and-forward TLP serializer for the PCIe receive path.
// Buffers one whole TLP arriving as 64-bit beats, then replays it as a
// 32-bit DWORD stream with a last flag. Whole-TLP buffering allows
// configuration TLPs to be dropped on request and oversize TLPs to be
// discarded without the host ever seeing a partial packet.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rx_data/keep/last/valid/ready   64-bit beat input (AXI-stream style)
//   dw_data/last/valid/ready        32-bit DWORD output stream
//   filter_cfg_en         drop CfgRd0/CfgWr0/CfgRd1/CfgWr1 TLPs when set
//   drop_count            saturating count of filtered TLPs
//   ovf_count             saturating count of oversize TLPs discarded
//   busy                  high whenever the FSM is not idle
//
// state   | meaning
// IDLE    | waiting for the first beat of a TLP
// FILL    | storing beats of the current TLP
// DRAIN   | replaying the buffered TLP as DWORDs, input stalled
// DISCARD | swallowing the rest of an oversize TLP
module pcileech_tlp_rx_dw_serializer #(
   parameter int MAX_BEATS = 18,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      rx_data,
   input  logic [7:0]       rx_keep,
   input  logic             rx_last,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [31:0]      dw_data,
   output logic             dw_last,
   output logic             dw_valid,
   input  logic             dw_ready,
   input  logic             filter_cfg_en,
   output logic [CNT_W-1:0] drop_count,
   output logic [CNT_W-1:0] ovf_count,
   output logic             busy
);
   localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam int TOT_W = $clog2(2 * MAX_BEATS + 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DISCARD} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TOT_W-1:0]   dw_idx_q, dw_idx_d;
   logic [TOT_W-1:0]   total_q, total_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
   logic [63:0]        buf_q [MAX_BEATS];

   logic               wr_en;
   logic [IDX_W-1:0]   wr_idx;
   logic               accept;
   logic [TOT_W-1:0]   last_beats;
   logic [TOT_W-1:0]   total_calc;
   logic [31:0]        hdr_dw0;
   logic               is_cfg;
   logic [IDX_W-1:0]   rd_idx;
   logic [63:0]        rd_beat;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         dw_idx_q   <= '0;
         total_q    <= '0;
         drop_cnt_q <= '0;
         ovf_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         dw_idx_q   <= dw_idx_d;
         total_q    <= total_d;
         drop_cnt_q <= drop_cnt_d;
         ovf_cnt_q  <= ovf_cnt_d;
      end
   end

   // Beat storage needs no reset: the FSM never reads a slot before writing it.
   always_ff @(posedge clk) begin
      if (wr_en) buf_q[wr_idx] <= rx_data;
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      dw_idx_d   = dw_idx_q;
      total_d    = total_q;
      drop_cnt_d = drop_cnt_q;
      ovf_cnt_d  = ovf_cnt_q;
      wr_en      = 1'b0;
      wr_idx     = idx_q;

      accept = rx_valid && (state_q != S_DRAIN);

      // Beat count including the current (last) beat; a half beat trims one DWORD.
      last_beats = (state_q == S_FILL) ? TOT_W'(idx_q) + 1'b1 : TOT_W'(1);
      total_calc = {last_beats[TOT_W-2:0], 1'b0} - TOT_W'(rx_keep == 8'h0f);

      // For a single-beat TLP the header is still on the bus, not in the buffer.
      hdr_dw0 = (state_q == S_IDLE) ? rx_data[31:0] : buf_q[0][31:0];
      is_cfg  = filter_cfg_en && (hdr_dw0[28:25] == 4'b0010);

      case (state_q)
         S_IDLE, S_FILL: begin
            if (accept) begin
               wr_en  = 1'b1;
               wr_idx = (state_q == S_IDLE) ? '0 : idx_q;
               if (rx_last) begin
                  idx_d = '0;
                  if (is_cfg) begin
                     state_d = S_IDLE;
                     if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
                  end else begin
                     state_d  = S_DRAIN;
                     total_d  = total_calc;
                     dw_idx_d = '0;
                  end
               end else if (wr_idx == IDX_W'(MAX_BEATS - 1)) begin
                  state_d = S_DISCARD;
                  idx_d   = '0;
                  if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
               end else begin
                  state_d = S_FILL;
                  idx_d   = wr_idx + 1'b1;
               end
            end
         end
         S_DISCARD: begin
            if (accept && rx_last) state_d = S_IDLE;
         end
         S_DRAIN: begin
            if (dw_ready) begin
               if (dw_idx_q == total_q - 1'b1) begin
                  state_d  = S_IDLE;
                  dw_idx_d = '0;
               end else begin
                  dw_idx_d = dw_idx_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      rd_idx     = IDX_W'(dw_idx_q >> 1);
      rd_beat    = buf_q[rd_idx];
      rx_ready   = (state_q != S_DRAIN);
      dw_valid   = (state_q == S_DRAIN);
      dw_last    = (state_q == S_DRAIN) && (dw_idx_q == total_q - 1'b1);
      dw_data    = '0;
      if (state_q == S_DRAIN) dw_data = dw_idx_q[0] ? rd_beat[63:32] : rd_beat[31:0];
      busy       = (state_q != S_IDLE);
      drop_count = drop_cnt_q;
      ovf_count  = ovf_cnt_q;
   end
endmodule
